fpga_rst_seq_ctrl: RTL and testbench
====================================

// Module: fpga_rst_seq_ctrl
// PURPOSE
// Reset/boot sequencer for the FPGA top level. Sits between the board reset and clock-wizard lock
// and the x_trela SoC. Holds the SoC and peripherals in reset until the clock is stable, then releases
// them in stages. Captures the program exit status and drives the status LEDs.
// PARAMETERS
// SYNC_STAGES     2   flop stages on the mmcm_locked_i synchronizer (min 2)
// LOCK_STABLE     64  cycles mmcm_locked must stay high continuously before the reset sequence starts
// HOLD_CYCLES     16  cycles both resets stay asserted after lock is qualified (min 1)
// STAGGER_CYCLES  4   cycles between periph reset release and SoC reset release (min 1)
// BLINK_LEN       27  width of the free-running LED counter; slow blink = bit BLINK_LEN-1
// FAST_SHIFT      3   fast blink = counter bit BLINK_LEN-1-FAST_SHIFT
// PORTS
// clk_gen        in   1   clock from the clock wizard
// rst_n          in   1   asynchronous, active-low reset (board button, already inverted)
// mmcm_locked_i  in   1   clock-wizard locked; asynchronous to clk_gen
// sw_rst_req_i   in   1   single-cycle software/debug reset request, clk_gen domain
// exit_valid_i   in   1   SoC exit_valid, clk_gen domain
// exit_value_i   in   32  SoC exit value; sampled only when exit_valid_i=1
// periph_rst_no  out  1   active-low peripheral reset
// soc_rst_no     out  1   active-low SoC (core + bus) reset
// rst_led_o      out  1   1 when both resets are released
// status_led_o   out  1   run/exit indication
// exit_done_o    out  1   exit has been captured
// exit_pass_o    out  1   captured exit_value == 0
// state_o        out  3   current FSM state (debug)
// BEHAVIOUR
// - Reset: rst_n low asserts every output asynchronously. periph_rst_no=0, soc_rst_no=0, all LEDs=0,
//   exit_*=0, state_o=WAIT_LOCK, counters=0. Deassertion takes effect on the next clk_gen edge.
// - All outputs are registered. No combinational path exists from any input to any output.
// - lock_s = mmcm_locked_i after SYNC_STAGES flops. stab_cnt counts up while lock_s=1, clears on lock_s=0,
//   and saturates at LOCK_STABLE. lock_ok = (stab_cnt==LOCK_STABLE).
// - FSM states (enum in pkg): WAIT_LOCK=0, HOLD=1, STAGGER=2, RUN=3, DONE=4.
//   WAIT_LOCK: both resets asserted. On lock_ok -> HOLD, cnt=0.
//   HOLD:      both asserted. After HOLD_CYCLES cycles in HOLD (cnt==HOLD_CYCLES-1) -> STAGGER, cnt=0.
//   STAGGER:   periph_rst_no=1, soc_rst_no=0. After STAGGER_CYCLES cycles -> RUN.
//   RUN:       both released. On exit_valid_i=1: exit_done_o<=1, exit_pass_o<=(exit_value_i==0) -> DONE.
//   DONE:      both released. exit_* held. A later exit_valid_i is ignored (first exit wins).
// - Reset outputs are registered from the next state, so a release takes effect the cycle the state is
//   entered.
// - lock_s=0 in any state except WAIT_LOCK -> WAIT_LOCK next cycle. Both resets assert on that same edge.
//   exit_* clear. stab_cnt restarts.
// - sw_rst_req_i=1 in STAGGER/RUN/DONE -> HOLD, cnt=0. Both resets assert. exit_* clear.
//   In WAIT_LOCK/HOLD it is ignored; HOLD does not restart.
// - Priority on simultaneous events: lock loss > sw_rst_req_i > exit_valid_i > count expiry.
// - rst_led_o = (state is RUN or DONE), registered.
// - status_led_o: RUN -> slow blink. DONE & pass -> constant 1. DONE & fail -> fast blink. Otherwise 0.
// - The LED counter is free-running BLINK_LEN bits and wraps modulo 2^BLINK_LEN. It is not cleared by
//   state changes.
// - The phase counter is $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1) bits wide and never wraps
//   (cleared on every transition).
// STRUCTURE
// - fpga_rst_seq_pkg: typedef enum logic [2:0] rst_seq_state_e, plus the state encodings above.
// - Sub-module fpga_sync_bit (SYNC_STAGES flop chain, async reset to 0) for mmcm_locked_i.
// - The FSM, counters and LED logic stay in this module.
// TESTING (LOCK_STABLE=4, HOLD_CYCLES=8, STAGGER_CYCLES=4, SYNC_STAGES=2, BLINK_LEN=8, FAST_SHIFT=3)
// 1. rst_n low mid-RUN -> all outputs 0 immediately (before the next edge), state_o=0.
// 2. Release rst_n, locked=1 from cycle 0 -> periph_rst_no rises 14 cycles after locked
//    (2 sync + 4 stable + 8 hold). soc_rst_no rises 4 cycles later, together with rst_led_o.
// 3. Locked glitch high for 3 cycles, then low -> stays WAIT_LOCK, resets held. Then steady high ->
//    sequence as in test 2, counted from the new rising edge.
// 4. In RUN, exit_valid=1 with exit_value=0 -> exit_done=1, exit_pass=1, status_led constant 1.
//    Repeat with exit_value=0x5 -> exit_pass=0, status_led toggles every 16 cycles.
//    A second exit_valid in DONE -> no change.
// 5. sw_rst_req and exit_valid in the same RUN cycle -> HOLD, both resets asserted, exit_done stays 0.
//    Release follows 8+4 cycles later.
// 6. Locked drops in the same cycle as sw_rst_req during STAGGER -> WAIT_LOCK, resets asserted,
//    and no release until locked has been stable again.

Source files
------------

// File: rtl/fpga_rst_seq_pkg.sv
// Shared types and helpers for the FPGA reset/boot sequencer.
package fpga_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_STAGGER   = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } rst_seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fpga_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module fpga_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_gen,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fpga_rst_seq_ctrl.sv
// Reset/boot sequencer: qualifies clock lock, releases peripheral then SoC reset, captures exit status.
// state      | meaning
// WAIT_LOCK  | both resets held, waiting for a stable lock
// HOLD       | lock qualified, both resets held for HOLD_CYCLES
// STAGGER    | peripherals released, SoC still held
// RUN        | both released, waiting for program exit
// DONE       | exit captured, status held until reset
module fpga_rst_seq_ctrl
    import fpga_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_STABLE    = 64,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int BLINK_LEN      = 27,
    parameter int FAST_SHIFT     = 3
) (
    input  logic        clk_gen,
    input  logic        rst_n,
    input  logic        mmcm_locked_i,
    input  logic        sw_rst_req_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        periph_rst_no,
    output logic        soc_rst_no,
    output logic        rst_led_o,
    output logic        status_led_o,
    output logic        exit_done_o,
    output logic        exit_pass_o,
    output logic [2:0]  state_o
);

    localparam int STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int PH_W   = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);

    logic                 lock_s;
    logic                 lock_ok;
    rst_seq_state_e       state_q, state_d;
    logic [STAB_W-1:0]    stab_cnt_q, stab_cnt_d;
    logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
    logic [BLINK_LEN-1:0] led_cnt_q, led_cnt_d;
    logic                 exit_done_q, exit_done_d;
    logic                 exit_pass_q, exit_pass_d;
    logic                 periph_rst_n_q, periph_rst_n_d;
    logic                 soc_rst_n_q, soc_rst_n_d;
    logic                 rst_led_q, rst_led_d;
    logic                 status_led_q, status_led_d;

    fpga_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_gen (clk_gen),
        .rst_n   (rst_n),
        .d_i     (mmcm_locked_i),
        .q_o     (lock_s)
    );

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (!lock_s) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_W'(LOCK_STABLE)) begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
        led_cnt_d = led_cnt_q + BLINK_LEN'(1);
    end

    assign lock_ok = (stab_cnt_q == STAB_W'(LOCK_STABLE));

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: lock loss, then software reset, then exit capture, then phase expiry.
    always_comb begin
        state_d     = state_q;
        ph_cnt_d    = (state_q == ST_HOLD || state_q == ST_STAGGER) ? ph_cnt_q + PH_W'(1) : '0;
        exit_done_d = exit_done_q;
        exit_pass_d = exit_pass_q;
        if (state_q != ST_WAIT_LOCK && !lock_s) begin
            state_d     = ST_WAIT_LOCK;
            ph_cnt_d    = '0;
            exit_done_d = 1'b0;
            exit_pass_d = 1'b0;
        end else if (sw_rst_req_i && (state_q inside {ST_STAGGER, ST_RUN, ST_DONE})) begin
            state_d     = ST_HOLD;
            ph_cnt_d    = '0;
            exit_done_d = 1'b0;
            exit_pass_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_d  = ST_HOLD;
                        ph_cnt_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (ph_cnt_q == PH_W'(HOLD_CYCLES - 1)) begin
                        state_d  = ST_STAGGER;
                        ph_cnt_d = '0;
                    end
                end
                ST_STAGGER: begin
                    if (ph_cnt_q == PH_W'(STAGGER_CYCLES - 1)) begin
                        state_d  = ST_RUN;
                        ph_cnt_d = '0;
                    end
                end
                ST_RUN: begin
                    if (exit_valid_i) begin
                        state_d     = ST_DONE;
                        exit_done_d = 1'b1;
                        exit_pass_d = (exit_value_i == 32'd0);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d  = ST_WAIT_LOCK;
                    ph_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so a release lands on the entry edge.
    always_comb begin
        periph_rst_n_d = (state_d inside {ST_STAGGER, ST_RUN, ST_DONE});
        soc_rst_n_d    = (state_d inside {ST_RUN, ST_DONE});
        rst_led_d      = soc_rst_n_d;
        status_led_d   = 1'b0;
        case (state_d)
            ST_RUN:  status_led_d = led_cnt_d[BLINK_LEN-1];
            ST_DONE: status_led_d = exit_pass_d ? 1'b1 : led_cnt_d[BLINK_LEN-1-FAST_SHIFT];
            default: status_led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt_q     <= '0;
            ph_cnt_q       <= '0;
            led_cnt_q      <= '0;
            exit_done_q    <= 1'b0;
            exit_pass_q    <= 1'b0;
            periph_rst_n_q <= 1'b0;
            soc_rst_n_q    <= 1'b0;
            rst_led_q      <= 1'b0;
            status_led_q   <= 1'b0;
        end else begin
            stab_cnt_q     <= stab_cnt_d;
            ph_cnt_q       <= ph_cnt_d;
            led_cnt_q      <= led_cnt_d;
            exit_done_q    <= exit_done_d;
            exit_pass_q    <= exit_pass_d;
            periph_rst_n_q <= periph_rst_n_d;
            soc_rst_n_q    <= soc_rst_n_d;
            rst_led_q      <= rst_led_d;
            status_led_q   <= status_led_d;
        end
    end

    assign periph_rst_no = periph_rst_n_q;
    assign soc_rst_no    = soc_rst_n_q;
    assign rst_led_o     = rst_led_q;
    assign status_led_o  = status_led_q;
    assign exit_done_o   = exit_done_q;
    assign exit_pass_o   = exit_pass_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_fpga_rst_seq_ctrl.sv
// Scoreboard bench for fpga_rst_seq_ctrl: timestamp-based reference model plus directed latency checks.
module tb_fpga_rst_seq_ctrl;

    localparam int SYNC = 2;
    localparam int LS   = 4;
    localparam int HC   = 8;
    localparam int SC   = 4;
    localparam int BL   = 8;
    localparam int FS   = 3;

    logic        clk_gen = 1'b0;
    logic        rst_n = 1'b0;
    logic        mmcm_locked_i = 1'b0;
    logic        sw_rst_req_i = 1'b0;
    logic        exit_valid_i = 1'b0;
    logic [31:0] exit_value_i = '0;
    logic        periph_rst_no, soc_rst_no, rst_led_o, status_led_o, exit_done_o, exit_pass_o;
    logic [2:0]  state_o;

    fpga_rst_seq_ctrl #(
        .SYNC_STAGES    (SYNC),
        .LOCK_STABLE    (LS),
        .HOLD_CYCLES    (HC),
        .STAGGER_CYCLES (SC),
        .BLINK_LEN      (BL),
        .FAST_SHIFT     (FS)
    ) dut (
        .clk_gen       (clk_gen),
        .rst_n         (rst_n),
        .mmcm_locked_i (mmcm_locked_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .exit_valid_i  (exit_valid_i),
        .exit_value_i  (exit_value_i),
        .periph_rst_no (periph_rst_no),
        .soc_rst_no    (soc_rst_no),
        .rst_led_o     (rst_led_o),
        .status_led_o  (status_led_o),
        .exit_done_o   (exit_done_o),
        .exit_pass_o   (exit_pass_o),
        .state_o       (state_o)
    );

    initial begin
        forever #5 clk_gen = ~clk_gen;
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];

    // Reference model: a sequence is described by its start edge (HOLD entry) and the
    // elapsed edge count since then, rather than by per-state counters.
    int m_cyc;
    int m_t0;
    int m_run;
    bit m_active;
    bit m_exited;
    bit m_pass;
    bit m_lock_s;
    bit sync_hist[$];

    function automatic int m_state();
        int e;
        if (!m_active) return 0;
        e = m_cyc - m_t0;
        if (e < HC) return 1;
        if (e < HC + SC) return 2;
        return m_exited ? 4 : 3;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_t0 = 0; m_run = 0;
        m_active = 0; m_exited = 0; m_pass = 0; m_lock_s = 0;
        sync_hist = {};
        for (int i = 0; i < SYNC; i++) sync_hist.push_back(1'b0);
    endtask

    task automatic model_step();
        int old_st;
        int st;
        logic [8:0] v;
        bit led;
        old_st = m_state();
        m_cyc++;
        if (old_st != 0 && !m_lock_s) begin
            m_active = 0;
            m_exited = 0;
        end else if (sw_rst_req_i && old_st >= 2) begin
            m_t0 = m_cyc;
            m_exited = 0;
        end else if (old_st == 0) begin
            if (m_run >= LS) begin
                m_active = 1;
                m_t0 = m_cyc;
            end
        end else if (old_st == 3 && exit_valid_i) begin
            m_exited = 1;
            m_pass = (exit_value_i == 32'd0);
        end
        m_run = m_lock_s ? m_run + 1 : 0;
        sync_hist.push_back(mmcm_locked_i);
        void'(sync_hist.pop_front());
        m_lock_s = sync_hist[0];
        st = m_state();
        led = 1'b0;
        if (st == 3) led = ((m_cyc >> (BL - 1)) & 1) != 0;
        if (st == 4) led = m_pass ? 1'b1 : (((m_cyc >> (BL - 1 - FS)) & 1) != 0);
        v = {(st >= 2), (st >= 3), (st >= 3), led, (st == 4), (st == 4) && m_pass, 3'(st)};
        exp_q.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk_gen);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    function automatic logic [8:0] dut_vec();
        return {periph_rst_no, soc_rst_no, rst_led_o, status_led_o, exit_done_o, exit_pass_o, state_o};
    endfunction

    // Monitor: outputs are compared against the scoreboard on every falling edge.
    initial begin
        logic [8:0] e;
        logic [8:0] g;
        forever begin
            @(negedge clk_gen);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_vec();
                n_checks++;
                if (g === e) n_pass++;
                else $display("FAIL outputs t=%0t got=%b exp=%b (periph,soc,rst_led,status,done,pass,state)",
                              $time, g, e);
            end
        end
    end

    task automatic measure(input string tag, input int exp_p, input int exp_s);
        int p;
        int s;
        p = -1;
        s = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            sw_rst_req_i = 1'b0;
            exit_valid_i = 1'b0;
            if (p < 0 && periph_rst_no) p = i;
            if (soc_rst_no) begin
                s = i;
                break;
            end
        end
        check({tag, "_periph_release"}, p, exp_p);
        check({tag, "_soc_release"}, s, exp_s);
        check({tag, "_rst_led"}, int'(rst_led_o), 1);
    endtask

    task automatic pulse_exit(input logic [31:0] val);
        exit_valid_i = 1'b1;
        exit_value_i = val;
        tick();
        exit_valid_i = 1'b0;
    endtask

    initial begin
        int tog;
        logic prev;
        int found;

        model_reset();
        #2;
        check("reset_outputs", int'(dut_vec()), 0);
        @(negedge clk_gen);
        #1;
        rst_n = 1'b1;

        // Clean power-up: lock from the first sampling edge.
        repeat (3) tick();
        mmcm_locked_i = 1'b1;
        measure("powerup", SYNC + LS + HC, SYNC + LS + HC + SC);

        // Exit with pass, then a second exit that must be ignored.
        repeat (5) tick();
        pulse_exit(32'd0);
        repeat (20) tick();
        check("pass_status_led", int'(status_led_o), 1);
        check("pass_exit_pass", int'(exit_pass_o), 1);
        pulse_exit(32'h5);
        repeat (5) tick();
        check("second_exit_ignored", int'(exit_pass_o), 1);

        // Software reset from DONE, then a failing exit.
        sw_rst_req_i = 1'b1;
        measure("swrst_done", HC, HC + SC);
        repeat (3) tick();
        pulse_exit(32'h5);
        check("fail_exit_done", int'(exit_done_o), 1);
        check("fail_exit_pass", int'(exit_pass_o), 0);
        tog = 0;
        prev = status_led_o;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (status_led_o != prev) tog++;
            prev = status_led_o;
        end
        check("fast_blink_toggles", tog, 4);

        // sw_rst_req and exit_valid together in RUN: reset wins.
        sw_rst_req_i = 1'b1;
        measure("swrst_fail", HC, HC + SC);
        repeat (4) tick();
        sw_rst_req_i = 1'b1;
        exit_valid_i = 1'b1;
        exit_value_i = 32'd0;
        tick();
        sw_rst_req_i = 1'b0;
        exit_valid_i = 1'b0;
        check("swrst_vs_exit_done", int'(exit_done_o), 0);
        check("swrst_vs_exit_state", int'(state_o), 1);
        measure("swrst_vs_exit", HC - 1, HC + SC - 1);

        // Lock loss reaching the FSM on the same edge as sw_rst_req during STAGGER.
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (periph_rst_no) begin
                found = 1;
                break;
            end
        end
        check("reach_stagger", found, 1);
        mmcm_locked_i = 1'b0;
        tick();
        tick();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        check("lockloss_vs_swrst_state", int'(state_o), 0);
        check("lockloss_vs_swrst_periph", int'(periph_rst_no), 0);
        repeat (6) tick();
        mmcm_locked_i = 1'b1;
        measure("relock", SYNC + LS + HC, SYNC + LS + HC + SC);

        // Short lock glitch must not start a sequence.
        mmcm_locked_i = 1'b0;
        repeat (10) tick();
        mmcm_locked_i = 1'b1;
        repeat (3) tick();
        mmcm_locked_i = 1'b0;
        repeat (10) tick();
        check("glitch_state", int'(state_o), 0);
        check("glitch_periph", int'(periph_rst_no), 0);
        mmcm_locked_i = 1'b1;
        measure("after_glitch", SYNC + LS + HC, SYNC + LS + HC + SC);

        // Asynchronous reset in the middle of RUN.
        repeat (10) tick();
        @(negedge clk_gen);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'(dut_vec()), 0);
        #20;
        model_reset();
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if (mmcm_locked_i) begin
                if ($urandom_range(0, 99) == 0) mmcm_locked_i = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                mmcm_locked_i = 1'b1;
            end
            sw_rst_req_i = ($urandom_range(0, 59) == 0);
            exit_valid_i = ($urandom_range(0, 14) == 0);
            exit_value_i = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom);
            tick();
        end
        sw_rst_req_i = 1'b0;
        exit_valid_i = 1'b0;

        repeat (2) @(negedge clk_gen);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
